// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-port arbiter sharing one external ALU with fixed 2-cycle grant-to-done latency
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic [3:0]   op0,
  input  logic [3:0]   op1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] res,
  output logic         zf,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [W-1:0] alu_c,
  input  logic         alu_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic ptr, sel, win1, idle;
  logic [W-1:0] ra, rb;
  logic [3:0] rop;
  // ptr holds the last-served port; port 1 wins only if alone or port 0 was served last
  always_comb begin
    idle = (state == IDLE) & ~rst;
    win1 = req1 & (~req0 | ~ptr);
    gnt1 = idle & win1;
    gnt0 = idle & req0 & ~win1;
    alu_a = (state == EXEC) ? ra : '0;
    alu_b = (state == EXEC) ? rb : '0;
    alu_op = (state == EXEC) ? rop : 4'b0000;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= 1'b1;
      sel <= 1'b0;
      ra <= '0;
      rb <= '0;
      rop <= 4'b0000;
      res <= '0;
      zf <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (state == IDLE) begin
        if (req0 | req1) begin
          sel <= win1;
          ra <= win1 ? a1 : a0;
          rb <= win1 ? b1 : b0;
          rop <= win1 ? op1 : op0;
          state <= EXEC;
        end
      end else if (state == EXEC) begin
        res <= alu_c;
        zf <= alu_zero;
        done0 <= ~sel;
        done1 <= sel;
        state <= RESP;
      end else begin
        ptr <= sel;
        state <= IDLE;
      end
    end
  end
endmodule
